// File: rtl/spi_master_param.sv
// spi_master_param: parametrised full-duplex SPI master with CPHA=0 and selectable CPOL (mode 0/2).
// Latency: accept edge to done = (2*DATA_W+2)*CLK_DIV clk; accept edge to next tx_ready = (2*DATA_W+3)*CLK_DIV clk.
// Backpressure: tx_ready is low from accept until the post-transfer gap ends; tx_valid is ignored (not queued) meanwhile.
// Optional feature macro SPI_LOOPBACK_EN: the rx path samples the internal mosi register instead of the miso port.
module spi_master_param #(
    parameter int DATA_W    = 12,
    parameter int CLK_DIV   = 10,
    parameter int MSB_FIRST = 0,
    parameter int CPOL      = 0
) (
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_tx_valid,
    output logic              o_tx_ready,
    input  logic [DATA_W-1:0] i_din,
    input  logic              i_miso,
    output logic              o_sclk,
    output logic              o_cs,
    output logic              o_mosi,
    output logic [DATA_W-1:0] o_rx_data,
    output logic              o_done,
    output logic              o_busy
);
    localparam int              DIV_W     = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam int              HP_W      = $clog2(2 * DATA_W);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
    localparam logic [HP_W-1:0]  HP_LAST  = HP_W'(2 * DATA_W - 1);
    localparam logic            SCLK_IDLE = (CPOL != 0);
    localparam logic            MSB       = (MSB_FIRST != 0);

    typedef enum logic [2:0] {S_IDLE, S_SETUP, S_SHIFT, S_HOLD, S_GAP} state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [DIV_W-1:0]  r_div;
    logic [HP_W-1:0]   r_hp_cnt;
    logic [DATA_W-1:0] r_tx_sh;
    logic [DATA_W-1:0] r_rx_sh;
    logic [DATA_W-1:0] r_rx_data;
    logic              r_sclk;
    logic              r_cs;
    logic              r_mosi;
    logic              r_tx_ready;
    logic              r_done;
    logic              r_busy;
    logic              w_accept;
    logic              w_hp_end;
    logic              w_lead;
    logic              w_trail;
    logic              w_rx_bit;

    assign w_accept = i_tx_valid && r_tx_ready;
    assign w_hp_end = (r_state != S_IDLE) && (r_div == DIV_LAST);
    // In SHIFT, an HP end with sclk still at idle level is a leading edge, otherwise trailing.
    assign w_lead   = (r_state == S_SHIFT) && w_hp_end && (r_sclk == SCLK_IDLE);
    assign w_trail  = (r_state == S_SHIFT) && w_hp_end && (r_sclk != SCLK_IDLE);

`ifdef SPI_LOOPBACK_EN
    logic w_unused_miso;
    assign w_unused_miso = i_miso;
    assign w_rx_bit      = r_mosi;
`else
    assign w_rx_bit      = i_miso;
`endif

    // State register.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) r_state <= S_IDLE;
        else          r_state <= w_state_nxt;
    end

    // Next-state logic: every non-idle phase advances on a half-period end.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nxt = S_SETUP;
            S_SETUP: if (w_hp_end) w_state_nxt = S_SHIFT;
            S_SHIFT: if (w_trail && (r_hp_cnt == HP_LAST)) w_state_nxt = S_HOLD;
            S_HOLD:  if (w_hp_end) w_state_nxt = S_GAP;
            S_GAP:   if (w_hp_end) w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Half-period divider and count of half-periods spent in SHIFT.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_div    <= '0;
            r_hp_cnt <= '0;
        end else begin
            if (r_state == S_IDLE || r_div == DIV_LAST) r_div <= '0;
            else                                         r_div <= r_div + DIV_W'(1);
            if (r_state != S_SHIFT) r_hp_cnt <= '0;
            else if (w_hp_end)      r_hp_cnt <= r_hp_cnt + HP_W'(1);
        end
    end

    // Registered handshake/framing outputs derived from the upcoming state.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_tx_ready <= 1'b1;
            r_busy     <= 1'b0;
            r_cs       <= 1'b1;
            r_sclk     <= SCLK_IDLE;
        end else begin
            r_tx_ready <= (w_state_nxt == S_IDLE);
            r_busy     <= (w_state_nxt != S_IDLE);
            r_cs       <= (w_state_nxt == S_IDLE) || (w_state_nxt == S_GAP);
            if (r_state == S_SHIFT && w_hp_end) r_sclk <= ~r_sclk;
            else if (r_state != S_SHIFT)        r_sclk <= SCLK_IDLE;
        end
    end

    // Transmit shifter: load on accept, present the next bit on each trailing edge, park mosi low at HOLD end.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_tx_sh <= '0;
            r_mosi  <= 1'b0;
        end else if (w_accept) begin
            r_tx_sh <= i_din;
            r_mosi  <= MSB ? i_din[DATA_W-1] : i_din[0];
        end else if (w_trail) begin
            if (MSB) begin
                r_tx_sh <= {r_tx_sh[DATA_W-2:0], 1'b0};
                r_mosi  <= r_tx_sh[DATA_W-2];
            end else begin
                r_tx_sh <= {1'b0, r_tx_sh[DATA_W-1:1]};
                r_mosi  <= r_tx_sh[1];
            end
        end else if (r_state == S_HOLD && w_hp_end) begin
            r_mosi <= 1'b0;
        end
    end

    // Receive shifter: capture on leading edges in the same bit order as transmit; publish with done.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_rx_sh   <= '0;
            r_rx_data <= '0;
            r_done    <= 1'b0;
        end else begin
            r_done <= 1'b0;
            if (w_lead) begin
                if (MSB) r_rx_sh <= {r_rx_sh[DATA_W-2:0], w_rx_bit};
                else     r_rx_sh <= {w_rx_bit, r_rx_sh[DATA_W-1:1]};
            end
            if (r_state == S_HOLD && w_hp_end) begin
                r_rx_data <= r_rx_sh;
                r_done    <= 1'b1;
            end
        end
    end

    assign o_tx_ready = r_tx_ready;
    assign o_busy     = r_busy;
    assign o_cs       = r_cs;
    assign o_sclk     = r_sclk;
    assign o_mosi     = r_mosi;
    assign o_rx_data  = r_rx_data;
    assign o_done     = r_done;

endmodule
